pingpong_ram_ctrl: RTL and testbench

PINGPONG_RAM_CTRL -- requirements
Module: pingpong_ram_ctrl

---
 rtl/pingpong_ram_ctrl.sv | 150 +++++++++++++++
 tb/tb_pingpong_ram_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_ram_ctrl.sv
// Ping-pong controller for two external block RAMs: the producer fills one bank
// while the consumer drains the other, with a 1-cycle registered read path.
module pingpong_ram_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 10,
  parameter int BLK_LEN = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [1:0]         ram_wen,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic [1:0]         ram_ren,
  output logic [A_WIDTH-1:0] ram_raddr,
  input  logic [D_WIDTH-1:0] ram0_rdata,
  input  logic [D_WIDTH-1:0] ram1_rdata,
  output logic [1:0]         bank_full
);

  localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(BLK_LEN - 1);

  typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

  rd_state_t          state_reg, state_next;
  logic               wr_bank_reg, wr_bank_next;
  logic               rd_bank_reg, rd_bank_next;
  logic [A_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
  logic [A_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;
  logic [1:0]         full_reg, full_next;
  logic               out_valid_reg, out_valid_next;
  logic               out_last_reg, out_last_next;
  logic               rd_sel_reg, rd_sel_next;

  logic wr_acc, rd_issue, wr_done, rd_done;

  assign in_ready = !full_reg[wr_bank_reg] && !flush;
  assign wr_acc   = in_valid && in_ready;
  assign rd_issue = (state_reg == RD_BUSY) && full_reg[rd_bank_reg] &&
                    (!out_valid_reg || out_ready);
  assign wr_done  = wr_acc && (wr_cnt_reg == LAST);
  assign rd_done  = rd_issue && (rd_cnt_reg == LAST);

  // Writer sets and reader clears always target different banks, so both apply.
  always_comb begin
    state_next     = state_reg;
    wr_bank_next   = wr_bank_reg;
    rd_bank_next   = rd_bank_reg;
    wr_cnt_next    = wr_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    full_next      = full_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    rd_sel_next    = rd_sel_reg;

    if (wr_acc) begin
      if (wr_done) begin
        full_next[wr_bank_reg] = 1'b1;
        wr_cnt_next            = '0;
        wr_bank_next           = ~wr_bank_reg;
      end else begin
        wr_cnt_next = wr_cnt_reg + 1'b1;
      end
    end

    if (rd_issue) begin
      if (rd_done) begin
        full_next[rd_bank_reg] = 1'b0;
        rd_cnt_next            = '0;
        rd_bank_next           = ~rd_bank_reg;
      end else begin
        rd_cnt_next = rd_cnt_reg + 1'b1;
      end
    end

    case (state_reg)
      RD_IDLE: if (full_reg[rd_bank_reg]) state_next = RD_BUSY;
      RD_BUSY: if (rd_done && !full_reg[~rd_bank_reg]) state_next = RD_IDLE;
      default: state_next = RD_IDLE;
    endcase

    if (rd_issue) begin
      out_valid_next = 1'b1;
      out_last_next  = (rd_cnt_reg == LAST);
      rd_sel_next    = rd_bank_reg;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RD_IDLE;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      full_reg      <= 2'b00;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      rd_sel_reg    <= 1'b0;
    end else if (flush) begin
      state_reg     <= RD_IDLE;
      wr_bank_reg   <= 1'b0;
      rd_bank_reg   <= 1'b0;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      full_reg      <= 2'b00;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      rd_sel_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_bank_reg   <= wr_bank_next;
      rd_bank_reg   <= rd_bank_next;
      wr_cnt_reg    <= wr_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      full_reg      <= full_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      rd_sel_reg    <= rd_sel_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign ram_wen[gi] = wr_acc && (wr_bank_reg == 1'(gi));
      assign ram_ren[gi] = rd_issue && (rd_bank_reg == 1'(gi));
    end
  endgenerate

  assign ram_waddr = wr_cnt_reg;
  assign ram_wdata = in_data;
  assign ram_raddr = rd_cnt_reg;
  // Bank RAMs hold rdata while ren is low, so this mux keeps a stalled word stable.
  assign out_data  = rd_sel_reg ? ram1_rdata : ram0_rdata;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign bank_full = full_reg;

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Scoreboard bench for pingpong_ram_ctrl with BLK_LEN=4 and behavioural bank RAMs.
module tb_pingpong_ram_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_last, out_ready;
  logic [DW-1:0] in_data, out_data, ram_wdata, ram0_rdata, ram1_rdata;
  logic [1:0]    ram_wen, ram_ren, bank_full;
  logic [AW-1:0] ram_waddr, ram_raddr;

  pingpong_ram_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .BLK_LEN(BL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr),
    .ram0_rdata(ram0_rdata), .ram1_rdata(ram1_rdata), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem0 [2**AW];
  logic [DW-1:0] mem1 [2**AW];
  always @(posedge clk) begin
    if (ram_wen[0]) mem0[ram_waddr] <= ram_wdata;
    if (ram_wen[1]) mem1[ram_waddr] <= ram_wdata;
    if (ram_ren[0]) ram0_rdata <= mem0[ram_raddr];
    if (ram_ren[1]) ram1_rdata <= mem1[ram_raddr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted write pushes {last, data}; each output handshake pops.
  logic [DW:0]   sb_q [$];
  int            mcnt = 0;
  logic          mbank = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] hdata;
  logic          hlast;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst || flush) begin
      sb_q.delete();
      mcnt  = 0;
      mbank = 1'b0;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hdata);
        chk("hold_last", out_last, hlast);
      end
      if (in_valid && in_ready) begin
        chk("wen", ram_wen, mbank ? 2'b10 : 2'b01);
        chk("waddr", ram_waddr, mcnt);
        chk("wdata", ram_wdata, in_data);
        sb_q.push_back({mcnt == BL - 1, in_data});
        if (mcnt == BL - 1) begin
          mcnt  = 0;
          mbank = ~mbank;
        end else begin
          mcnt++;
        end
      end else begin
        chk("wen_idle", ram_wen, 0);
      end
      if (out_valid && !out_ready) chk("ren_stall", ram_ren, 0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra: got %0h expected no word at %0t", out_data, $time);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e[DW-1:0]);
          chk("out_last", out_last, e[DW]);
        end
      end
      hold  = out_valid && !out_ready;
      hdata = out_data;
      hlast = out_last;
    end
  end

  task automatic stream(input logic [DW-1:0] base, input int n, output int stalls);
    logic acc;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      acc      = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (!acc) stalls++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drained", sb_q.size(), 0);
    chk("drained_full", bank_full, 2'b00);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_ren", ram_ren, 0);
    @(posedge clk); #1;

    // Single block: bank_full rises, first word 2 cycles later.
    out_ready = 1'b1;
    stream(8'h10, 4, st);
    chk("t1_stalls", st, 0);
    @(negedge clk);
    chk("t1_bank_full", bank_full, 2'b01);
    chk("t1_valid_e0", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_e1", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_e2", out_valid, 1);
    chk("t1_first", out_data, 8'h10);
    @(posedge clk); #1;
    drain();

    // 12-word stream: only the reader's idle-to-busy cycle on the first block stalls.
    do_flush();
    stream(8'h00, 12, st);
    chk("t2_stalls", st, 1);
    drain();

    // Backpressure: both banks fill, 9th word refused, then drain.
    do_flush();
    out_ready = 1'b0;
    stream(8'h20, 8, st);
    chk("t3_stalls", st, 0);
    @(negedge clk);
    chk("t3_bank_full", bank_full, 2'b11);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 8'h20);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hff;
    @(negedge clk);
    chk("t3_9th_refused", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("t3_ready_back", in_ready, 1);
    chk("t3_bank0_freed", bank_full, 2'b10);
    @(posedge clk); #1;
    drain();

    // Toggling out_ready during drain.
    do_flush();
    out_ready = 1'b0;
    stream(8'h30, 8, st);
    for (int t = 0; t < 24; t++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-block discards the partial block.
    do_flush();
    out_ready = 1'b1;
    stream(8'h40, 2, st);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stream(8'h50, 4, st);
    drain();

    // Flush with a word presented.
    out_ready = 1'b0;
    stream(8'h60, 4, st);
    for (int t = 0; t < 10; t++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("t6_valid_before", out_valid, 1);
    do_flush();
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_bank_full", bank_full, 2'b00);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
